// File: rtl/gshare_pht.sv
// ---------------------------------------------------------------------------
// gshare_pht
//
// Pattern history table for the fetch-stage gshare predictor.
//
// A lookup hashes the fetch PC with the global history snapshot, reads the
// 2-bit saturating counter at that index and returns a registered
// taken/not-taken prediction together with the index used.  The index
// travels down the pipe with the branch and comes back at resolve, where the
// actual outcome trains the same counter.  Saturating statistics counters
// track resolved branches and mispredicts.
//
// Ports
//   clock, reset        : posedge clock, synchronous active-high reset
//   fetch_valid         : lookup request this cycle
//   fetch_pc            : PC of the fetched instruction
//   ghr_fetch           : global history snapshot at fetch
//   pred_valid          : registered fetch_valid
//   pred_taken          : registered prediction (counter MSB)
//   pred_index          : registered table index, carried to resolve
//   upd_valid           : resolved conditional branch this cycle
//   upd_index           : index returned from the pipe
//   upd_taken           : actual outcome
//   upd_pred_taken      : prediction originally made for this branch
//   mispredict          : registered upd_valid && (upd_taken != upd_pred_taken)
//   branch_count        : resolved branches, saturating
//   mispredict_count    : mispredicts, saturating
//
// Handshake: both the lookup and the update channels are valid-only.  There
// is no ready; a request is consumed in every cycle its valid is high and
// reset is low, and a request presented in a reset cycle is dropped.
// ---------------------------------------------------------------------------
module gshare_pht #(
    parameter int GHR_W   = 6,
    parameter int INDEX_W = 6,
    parameter int PC_W    = 32,
    parameter int PC_LSB  = 2,
    parameter int STAT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               fetch_valid,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic [GHR_W-1:0]   ghr_fetch,

    output logic               pred_valid,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_index,

    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    input  logic               upd_pred_taken,

    output logic               mispredict,
    output logic [STAT_W-1:0]  branch_count,
    output logic [STAT_W-1:0]  mispredict_count
);

    localparam int DEPTH = 1 << INDEX_W;

    // Per-entry 2-bit counter states; the MSB is the prediction.
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_t;

    // Saturating step of one counter toward the observed outcome.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        unique case (cur)
            CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
            CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
            CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
            CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
            default:       nxt = CTR_WEAK_NT;
        endcase
        return nxt;
    endfunction

    // -----------------------------------------------------------------------
    // Table storage
    // -----------------------------------------------------------------------
    ctr_t table_q [DEPTH];

    // -----------------------------------------------------------------------
    // Index hash and update path
    // -----------------------------------------------------------------------
    logic [INDEX_W-1:0] fetch_index;
    ctr_t               upd_ctr_cur;
    ctr_t               upd_ctr_new;
    ctr_t               lookup_ctr;
    logic               same_index;

    assign fetch_index = fetch_pc[PC_LSB +: INDEX_W] ^ ghr_fetch;

    always_comb begin
        upd_ctr_cur = table_q[upd_index];
        upd_ctr_new = ctr_next(upd_ctr_cur, upd_taken);
    end

    // Write-then-read: a lookup that hits the entry being trained this cycle
    // sees the trained value, so back-to-back branches on a hot index do not
    // act on a stale counter.
    always_comb begin
        same_index = upd_valid && (upd_index == fetch_index);
        lookup_ctr = same_index ? upd_ctr_new : table_q[fetch_index];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= CTR_WEAK_NT;
            end
        end else if (upd_valid) begin
            table_q[upd_index] <= upd_ctr_new;
        end
    end

    // -----------------------------------------------------------------------
    // Prediction output register.  With no lookup, taken/index hold so the
    // last prediction stays observable; only pred_valid drops.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= fetch_valid;
            if (fetch_valid) begin
                pred_taken <= lookup_ctr[1];
                pred_index <= fetch_index;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Mispredict flag and saturating statistics
    // -----------------------------------------------------------------------
    logic upd_mispredict;
    logic branch_sat;
    logic mispredict_sat;

    always_comb begin
        upd_mispredict = upd_valid && (upd_taken != upd_pred_taken);
        branch_sat     = &branch_count;
        mispredict_sat = &mispredict_count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= upd_mispredict;
            if (upd_valid && !branch_sat) begin
                branch_count <= branch_count + STAT_W'(1);
            end
            if (upd_mispredict && !mispredict_sat) begin
                mispredict_count <= mispredict_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// ---------------------------------------------------------------------------
// tb_gshare_pht
//
// Directed steps followed by randomized traffic, checked against a counter
// model held in plain integer arrays.  A second instance with 3-bit
// statistics shares the stimulus to exercise saturation.
// ---------------------------------------------------------------------------
module tb_gshare_pht;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [5:0]  ghr_fetch;
    logic        upd_valid;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic        upd_pred_taken;

    logic        pred_valid, pred_taken, mispredict;
    logic [5:0]  pred_index;
    logic [15:0] branch_count, mispredict_count;

    logic        s_pred_valid, s_pred_taken, s_mispredict;
    logic [5:0]  s_pred_index;
    logic [2:0]  s_branch_count, s_mispredict_count;

    gshare_pht dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .ghr_fetch(ghr_fetch),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken),
        .mispredict(mispredict), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    gshare_pht #(.STAT_W(3)) dut_small (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .ghr_fetch(ghr_fetch),
        .pred_valid(s_pred_valid), .pred_taken(s_pred_taken), .pred_index(s_pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken),
        .mispredict(s_mispredict), .branch_count(s_branch_count),
        .mispredict_count(s_mispredict_count)
    );

    // -----------------------------------------------------------------------
    // Reference model: counters as integers 0..3, predict taken when >= 2
    // -----------------------------------------------------------------------
    int m_ctr [64];
    int e_pv, e_pt, e_pi, e_mis;
    int e_bc, e_mc, e_sbc, e_smc;

    int n_vec  = 0;
    int n_fail = 0;
    int mis_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare after.
    task automatic step(input bit rst, input bit fv, input logic [31:0] pc,
                        input logic [5:0] g, input bit uv, input logic [5:0] ui,
                        input bit ut, input bit upt);
        int idx;
        reset = rst; fetch_valid = fv; fetch_pc = pc; ghr_fetch = g;
        upd_valid = uv; upd_index = ui; upd_taken = ut; upd_pred_taken = upt;
        @(posedge clock);
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            e_pv = 0; e_pt = 0; e_pi = 0; e_mis = 0;
            e_bc = 0; e_mc = 0; e_sbc = 0; e_smc = 0;
        end else begin
            e_mis = (uv && (ut != upt)) ? 1 : 0;
            if (uv) begin
                e_bc  = sat_inc(e_bc, 65535);
                e_sbc = sat_inc(e_sbc, 7);
                if (e_mis == 1) begin
                    e_mc  = sat_inc(e_mc, 65535);
                    e_smc = sat_inc(e_smc, 7);
                end
                if (ut) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end
            if (fv) begin
                idx  = int'(pc[7:2] ^ g);
                e_pv = 1;
                e_pt = (m_ctr[idx] >= 2) ? 1 : 0;
                e_pi = idx;
            end else begin
                e_pv = 0;
            end
        end
        #1;
        check("pred_valid",        32'(pred_valid),         e_pv);
        check("pred_taken",        32'(pred_taken),         e_pt);
        check("pred_index",        32'(pred_index),         e_pi);
        check("mispredict",        32'(mispredict),         e_mis);
        check("branch_count",      32'(branch_count),       e_bc);
        check("mispredict_count",  32'(mispredict_count),   e_mc);
        check("small_branch_cnt",  32'(s_branch_count),     e_sbc);
        check("small_mispred_cnt", 32'(s_mispredict_count), e_smc);
        if (mispredict === 1'b1) mis_pulses++;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 6'h0, 0, 6'h0, 0, 0);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [5:0] g);
        step(0, 1, pc, g, 0, 6'h0, 0, 0);
    endtask

    task automatic train(input logic [5:0] ui, input bit ut);
        step(0, 0, 32'h0, 6'h0, 1, ui, ut, ut);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [31:0] pc;
        logic [5:0]  g;

        // Reset, then a plain lookup of index 4.
        step(1, 0, 32'h0, 6'h0, 0, 6'h0, 0, 0);
        step(1, 0, 32'h0, 6'h0, 0, 6'h0, 0, 0);
        lookup(32'h0000_0010, 6'h00);
        check("first_lookup_index", 32'(pred_index), 32'd4);
        check("first_lookup_taken", 32'(pred_taken), 32'd0);

        // Train index 4 up to strong-T, then down past strong-NT.
        train(6'd4, 1); train(6'd4, 1);
        lookup(32'h0000_0010, 6'h00);
        check("trained_taken", 32'(pred_taken), 32'd1);
        train(6'd4, 0); train(6'd4, 0); train(6'd4, 0);
        lookup(32'h0000_0010, 6'h00);
        check("trained_not_taken", 32'(pred_taken), 32'd0);
        train(6'd4, 0);
        lookup(32'h0000_0010, 6'h00);
        check("hold_strong_nt", 32'(pred_taken), 32'd0);

        // Hash: 0xFC -> PC bits 111111, xor 101010 -> 010101.
        lookup(32'h0000_00FC, 6'b101010);
        check("hash_index", 32'(pred_index), 32'd21);
        train(6'd21, 1);
        lookup(32'h0000_00FC, 6'b000000);
        check("hash_other_index", 32'(pred_index), 32'd63);
        check("hash_other_taken", 32'(pred_taken), 32'd0);

        // Same-cycle update and lookup of index 9 (weak-NT -> weak-T).
        step(0, 1, 32'h0000_0024, 6'h00, 1, 6'd9, 1, 0);
        check("forward_taken", 32'(pred_taken), 32'd1);
        lookup(32'h0000_0024, 6'h00);
        check("forward_persist", 32'(pred_taken), 32'd1);

        // Statistics: 5 updates, 2 mispredicted.
        step(1, 0, 32'h0, 6'h0, 0, 6'h0, 0, 0);
        mis_pulses = 0;
        step(0, 0, 32'h0, 6'h0, 1, 6'd1, 1, 1);
        step(0, 0, 32'h0, 6'h0, 1, 6'd2, 1, 0);
        step(0, 0, 32'h0, 6'h0, 1, 6'd3, 0, 0);
        step(0, 0, 32'h0, 6'h0, 1, 6'd4, 0, 1);
        step(0, 0, 32'h0, 6'h0, 1, 6'd5, 1, 1);
        idle();
        check("stats_branches",   32'(branch_count),     32'd5);
        check("stats_mispredict", 32'(mispredict_count), 32'd2);
        check("mispredict_pulses", 32'(mis_pulses),      32'd2);
        for (int i = 0; i < 5; i++) train(6'(i), 1);
        idle();
        check("small_saturated", 32'(s_branch_count), 32'd7);
        check("wide_not_saturated", 32'(branch_count), 32'd10);

        // Randomized traffic with occasional resets and forced conflicts.
        for (int n = 0; n < 600; n++) begin
            pc = $urandom;
            g  = 6'($urandom_range(0, 63));
            step(($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)), pc, g,
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0) ? (pc[7:2] ^ g) : 6'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Train a few entries, then reset while update and lookup are live.
        for (int i = 0; i < 3; i++) begin
            train(6'd10, 1); train(6'd11, 1);
        end
        step(1, 1, 32'h0000_0028, 6'h00, 1, 6'd10, 1, 0);
        check("reset_pred_valid", 32'(pred_valid),   32'd0);
        check("reset_pred_index", 32'(pred_index),   32'd0);
        check("reset_mispredict", 32'(mispredict),   32'd0);
        check("reset_branches",   32'(branch_count), 32'd0);
        lookup(32'h0000_0028, 6'h00);
        check("post_reset_idx10", 32'(pred_taken), 32'd0);
        lookup(32'h0000_002C, 6'h00);
        check("post_reset_idx11", 32'(pred_taken), 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
